// File: rtl/i2c_cfg_master.sv
// Write-only I2C master that streams NWORDS configuration words to one device after reset,
// retrying a word after a NACK up to MAX_RETRY times.
module i2c_cfg_master #(
  parameter logic [6:0] ADDR      = 7'h1A,
  parameter int         NWORDS    = 9,
  parameter int         WBYTES    = 2,
  parameter int         CLKDIV    = 64,
  parameter int         MAX_RETRY = 3,
  localparam int        IW        = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                  clock50,
  input  logic                  start,
  input  logic [WBYTES*8-1:0]   word_data,
  output logic [IW-1:0]         word_idx,
  output logic                  i2c_c,
  inout  wire                   i2c_d,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [7:0]            err_count
);

  localparam int             FW        = (WBYTES + 1) * 8;
  localparam int             CW        = $clog2(CLKDIV);
  localparam logic [CW-1:0]  DIV_LAST  = CW'(CLKDIV - 1);
  localparam logic [IW-1:0]  LAST_IDX  = IW'(NWORDS - 1);
  localparam logic [2:0]     LAST_BYTE = 3'(WBYTES);
  localparam logic [3:0]     RETRY_LIM = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE, S_FAIL
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   div_cnt;
  logic [1:0]      phase;
  logic [FW-1:0]   shreg;
  logic [2:0]      bit_cnt;
  logic [2:0]      byte_cnt;
  logic            nack;
  logic [3:0]      retry;
  logic            tick;
  logic            unit_end;
  logic            scl;
  logic            sda_low;

  assign tick     = (div_cnt == DIV_LAST);
  assign unit_end = tick && (phase == 2'd3);

  always_ff @(posedge clock50 or posedge start) begin
    if (start) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  always_ff @(posedge clock50 or posedge start) begin
    if (start) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Every state except IDLE lasts whole four-tick units; byte and word decisions happen at Q3.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (tick) next_state = S_START;
      S_START: if (unit_end) next_state = S_BIT;
      S_BIT:   if (unit_end && bit_cnt == 3'd7) next_state = S_ACK;
      S_ACK:   if (unit_end) next_state = (nack || byte_cnt == LAST_BYTE) ? S_STOP : S_BIT;
      S_STOP:  if (unit_end) next_state = S_GAP;
      S_GAP: begin
        if (unit_end) begin
          if (!nack) begin
            next_state = (word_idx == LAST_IDX) ? S_DONE : S_START;
          end else begin
            next_state = (retry != RETRY_LIM) ? S_START : S_FAIL;
          end
        end
      end
      default: next_state = state;
    endcase
  end

  // STOP keeps SDA low through Q3 so the release lands on GAP entry, making the idle gap exactly one GAP.
  always_comb begin
    scl     = 1'b1;
    sda_low = 1'b0;
    busy    = 1'b1;
    case (state)
      S_IDLE: busy = 1'b0;
      S_START: begin
        sda_low = 1'b1;
        scl     = (phase != 2'd3);
      end
      S_BIT: begin
        scl     = (phase == 2'd1) || (phase == 2'd2);
        sda_low = !shreg[FW-1];
      end
      S_ACK:  scl = (phase == 2'd1) || (phase == 2'd2);
      S_STOP: begin
        sda_low = 1'b1;
        scl     = (phase != 2'd0);
      end
      S_GAP:  busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign i2c_c = scl;
  assign i2c_d = sda_low ? 1'b0 : 1'bz;
  assign done  = (state == S_DONE);
  assign fail  = (state == S_FAIL);

  always_ff @(posedge clock50 or posedge start) begin
    if (start) begin
      phase     <= 2'd0;
      shreg     <= '0;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 3'd0;
      nack      <= 1'b0;
      retry     <= 4'd0;
      word_idx  <= '0;
      err_count <= 8'd0;
    end else if (tick) begin
      phase <= (state == S_IDLE) ? 2'd0 : phase + 2'd1;
      case (state)
        S_START: begin
          if (phase == 2'd3) begin
            shreg    <= {ADDR, 1'b0, word_data};
            bit_cnt  <= 3'd0;
            byte_cnt <= 3'd0;
          end
        end
        S_BIT: begin
          if (phase == 2'd3) begin
            shreg   <= {shreg[FW-2:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        S_ACK: begin
          if (phase == 2'd2) nack <= i2c_d;
          if (phase == 2'd3) begin
            byte_cnt <= byte_cnt + 3'd1;
            if (nack && err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        S_GAP: begin
          if (phase == 2'd3) begin
            if (!nack) begin
              retry <= 4'd0;
              if (word_idx != LAST_IDX) word_idx <= word_idx + IW'(1);
            end else if (retry != RETRY_LIM) begin
              retry <= retry + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cfg_master.sv
// Bench for i2c_cfg_master: a bus monitor/slave decodes frames and drives ACKs,
// scenario records hold the expected frames and final status.
module tb_i2c_cfg_master;

  logic clock50 = 1'b0;
  always #5 clock50 = ~clock50;

  localparam logic [2:0][15:0] STD_WORDS = {16'h0A00, 16'h0C00, 16'h1E00};

  logic             start;
  logic [2:0][15:0] words;
  logic [15:0]      word_data;
  logic [1:0]       word_idx;
  logic             i2c_c, busy, done, fail;
  logic [7:0]       err_count;
  wire              sda;
  logic             slave_low = 1'b0;

  assign sda = slave_low ? 1'b0 : 1'bz;
  pullup (sda);

  always_comb begin
    word_data = 16'h0000;
    for (int i = 0; i < 3; i++) if (word_idx == 2'(i)) word_data = words[i];
  end

  i2c_cfg_master #(.ADDR(7'h1A), .NWORDS(3), .WBYTES(2), .CLKDIV(4), .MAX_RETRY(3)) dut (
    .clock50(clock50), .start(start), .word_data(word_data), .word_idx(word_idx),
    .i2c_c(i2c_c), .i2c_d(sda), .busy(busy), .done(done), .fail(fail), .err_count(err_count)
  );

  // Second instance: one word, one data byte, no retries, nobody ever ACKs.
  logic       start2;
  logic [7:0] word_data2;
  logic       word_idx2, i2c_c2, busy2, done2, fail2;
  logic [7:0] err_count2;
  wire        sda2;
  pullup (sda2);
  assign word_data2 = 8'hA5;

  i2c_cfg_master #(.ADDR(7'h1A), .NWORDS(1), .WBYTES(1), .CLKDIV(4), .MAX_RETRY(0)) dut2 (
    .clock50(clock50), .start(start2), .word_data(word_data2), .word_idx(word_idx2),
    .i2c_c(i2c_c2), .i2c_d(sda2), .busy(busy2), .done(done2), .fail(fail2), .err_count(err_count2)
  );

  typedef struct packed {
    logic [7:0]  n;
    logic [31:0] d;
  } fr_t;

  fr_t        frames[$];
  int         mode;
  int         frame_no, mbit_cnt, byte_idx, cur_n;
  int         starts, stops, hi8, hi_other, hi_bad, lo8, lo_other, gaps, gap_bad, gap_len, len;
  bit         in_frame, gap_on, seen_rise, seen_fall, prev_scl, prev_sda;
  logic [7:0] cur_byte;
  logic [31:0] cur_d;

  // Monitor and slave: decodes START/STOP, bits on SCL rise, drives ACK from the 8th fall to the 9th fall.
  always @(negedge clock50) begin
    if (start) begin
      frames.delete();
      frame_no = 0; mbit_cnt = 0; byte_idx = 0; cur_n = 0; cur_d = 0; cur_byte = 0;
      starts = 0; stops = 0; hi8 = 0; hi_other = 0; hi_bad = 0; lo8 = 0; lo_other = 0;
      gaps = 0; gap_bad = 0; gap_len = 0; len = 0;
      in_frame = 0; gap_on = 0; seen_rise = 0; seen_fall = 0; prev_scl = 1; prev_sda = 1;
      slave_low = 1'b0;
    end else begin
      if (i2c_c && prev_scl && prev_sda && !sda) begin
        starts++; frame_no++; in_frame = 1; mbit_cnt = 0; byte_idx = 0; cur_d = 0; cur_n = 0;
        if (gap_on) begin
          gaps++;
          if (gap_len != 16) gap_bad++;
          gap_on = 0;
        end
      end else if (i2c_c && prev_scl && !prev_sda && sda) begin
        stops++;
        if (in_frame) frames.push_back({8'(cur_n), cur_d});
        in_frame = 0; gap_on = 1; gap_len = 0;
      end
      if (gap_on) gap_len++;
      if (i2c_c != prev_scl) begin
        if (prev_scl) begin
          if (seen_rise) begin
            if (len == 8) hi8++;
            else begin
              hi_other++;
              if (len != 40) hi_bad++;
            end
          end
          seen_fall = 1;
          if (in_frame && mbit_cnt == 8) begin
            cur_d = {cur_d[23:0], cur_byte}; cur_n++;
            slave_low = (mode == 0) || (mode == 1 && !(frame_no == 2 && byte_idx == 2));
          end else if (in_frame && mbit_cnt == 9) begin
            slave_low = 1'b0; mbit_cnt = 0; byte_idx++;
          end
        end else begin
          if (seen_fall) begin
            if (len == 8) lo8++;
            else lo_other++;
          end
          seen_rise = 1;
          if (in_frame && mbit_cnt < 8) begin
            cur_byte = {cur_byte[6:0], sda}; mbit_cnt++;
          end else if (in_frame && mbit_cnt == 8) begin
            mbit_cnt = 9;
          end
        end
        len = 1;
      end else begin
        len++;
      end
      prev_scl = i2c_c; prev_sda = sda;
    end
  end

  int starts2;
  bit p2s, p2d;
  always @(negedge clock50) begin
    if (start2) begin
      starts2 = 0; p2s = 1; p2d = 1;
    end else begin
      if (i2c_c2 && p2s && p2d && !sda2) starts2++;
      p2s = i2c_c2; p2d = sda2;
    end
  end

  typedef struct packed {
    logic [1:0]       mode;
    logic             scramble;
    logic [2:0]       nframes;
    logic [3:0][23:0] frames;
    logic [7:0]       nbytes;
    logic             done;
    logic             fail;
    logic [7:0]       err;
    logic [1:0]       idx;
  } vec_t;

  vec_t vecs[3];
  int   checks, passes;

  function automatic vec_t mkVec(input logic [1:0] m, input logic scr, input logic [2:0] nf,
                                 input logic [23:0] f0, input logic [23:0] f1, input logic [23:0] f2,
                                 input logic [23:0] f3, input logic [7:0] nb, input logic d,
                                 input logic f, input logic [7:0] e, input logic [1:0] ix);
    vec_t v;
    v.mode = m; v.scramble = scr; v.nframes = nf; v.frames = {f3, f2, f1, f0};
    v.nbytes = nb; v.done = d; v.fail = f; v.err = e; v.idx = ix;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input int m);
    @(negedge clock50);
    start = 1'b1; mode = m; words = STD_WORDS;
    repeat (3) @(negedge clock50);
    start = 1'b0;
  endtask

  task automatic waitEnd(output bit ok);
    ok = 0;
    for (int c = 0; c < 8000; c++) begin
      @(posedge clock50);
      if (done || fail) begin ok = 1; break; end
    end
    repeat (4) @(posedge clock50);
    #1;
  endtask

  task automatic waitMon(input int fno, input int byi, input int bitn, output bit ok);
    ok = 0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clock50);
      if (frame_no == fno && byte_idx == byi && (bitn < 0 || mbit_cnt == bitn)) begin ok = 1; break; end
    end
  endtask

  task automatic checkFrames(input string tag, input vec_t v);
    checkOutput({tag, " frame count"}, frames.size(), 32'(v.nframes));
    for (int f = 0; f < int'(v.nframes) && f < frames.size(); f++) begin
      checkOutput($sformatf("%s frame%0d data", tag, f), frames[f].d, 32'(v.frames[f]));
      checkOutput($sformatf("%s frame%0d bytes", tag, f), 32'(frames[f].n), 32'(v.nbytes));
    end
  endtask

  initial begin
    bit ok;
    string tag;
    checks = 0; passes = 0;
    start = 1'b1; start2 = 1'b1; mode = 0; words = STD_WORDS;

    vecs[0] = mkVec(2'd0, 1'b1, 3'd3, 24'h341E00, 24'h340C00, 24'h340A00, 24'h0, 8'd3, 1, 0, 8'd0, 2'd2);
    vecs[1] = mkVec(2'd1, 1'b0, 3'd4, 24'h341E00, 24'h340C00, 24'h340C00, 24'h340A00, 8'd3, 1, 0, 8'd1, 2'd2);
    vecs[2] = mkVec(2'd2, 1'b0, 3'd4, 24'h34, 24'h34, 24'h34, 24'h34, 8'd1, 0, 1, 8'd4, 2'd0);

    repeat (3) @(posedge clock50);
    #1;
    checkOutput("reset scl", i2c_c, 1);
    checkOutput("reset sda", sda, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset fail", fail, 0);
    checkOutput("reset err_count", err_count, 0);
    checkOutput("reset word_idx", word_idx, 0);

    for (int i = 0; i < 3; i++) begin
      tag = $sformatf("vec%0d", i);
      applyStimulus(int'(vecs[i].mode));
      repeat (10) @(posedge clock50);
      #1;
      checkOutput({tag, " busy running"}, busy, 1);
      if (vecs[i].scramble) begin
        waitMon(1, 1, -1, ok);
        checkOutput({tag, " reached frame0 data byte"}, ok, 1);
        words[0] = 16'hFFFF;
      end
      waitEnd(ok);
      checkOutput({tag, " finished in budget"}, ok, 1);
      checkOutput({tag, " done"}, done, vecs[i].done);
      checkOutput({tag, " fail"}, fail, vecs[i].fail);
      checkOutput({tag, " err_count"}, err_count, vecs[i].err);
      checkOutput({tag, " word_idx"}, word_idx, vecs[i].idx);
      checkOutput({tag, " busy end"}, busy, 0);
      checkOutput({tag, " scl idle"}, i2c_c, 1);
      checkOutput({tag, " sda released"}, sda, 1);
      checkFrames(tag, vecs[i]);
      if (i == 0) begin
        checkOutput("scl high 8 count", hi8, 81);
        checkOutput("scl long highs", hi_other, 2);
        checkOutput("scl long high not 40", hi_bad, 0);
        checkOutput("scl low 8 count", lo8, 84);
        checkOutput("scl low other", lo_other, 0);
        checkOutput("idle gaps", gaps, 2);
        checkOutput("idle gap not 16", gap_bad, 0);
        checkOutput("start conditions", starts, 3);
        checkOutput("stop conditions", stops, 3);
      end
    end

    applyStimulus(0);
    waitMon(2, 1, 5, ok);
    checkOutput("abort trigger reached", ok, 1);
    #2;
    start = 1'b1;
    #1;
    checkOutput("abort scl", i2c_c, 1);
    checkOutput("abort sda", sda, 1);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort word_idx", word_idx, 0);
    checkOutput("abort done", done, 0);
    repeat (3) @(negedge clock50);
    start = 1'b0;
    waitEnd(ok);
    checkOutput("restart finished", ok, 1);
    checkOutput("restart done", done, 1);
    checkOutput("restart err_count", err_count, 0);
    checkOutput("restart word_idx", word_idx, 2);
    checkFrames("restart", vecs[0]);

    @(negedge clock50);
    start2 = 1'b0;
    ok = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clock50);
      if (done2 || fail2) begin ok = 1; break; end
    end
    repeat (4) @(posedge clock50);
    #1;
    checkOutput("single finished", ok, 1);
    checkOutput("single fail", fail2, 1);
    checkOutput("single done", done2, 0);
    checkOutput("single err_count", err_count2, 1);
    checkOutput("single attempts", starts2, 1);
    checkOutput("single busy", busy2, 0);
    checkOutput("single scl", i2c_c2, 1);
    checkOutput("single sda", sda2, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
